// File: rtl/sys_step_ctrl.sv
// sys_step_ctrl: front-panel execution controller.
// Synchronises and debounces the step/load buttons and the run switch, then
// drives a one-cycle CPU clock-enable (single-step or free-run divider), a
// PC-load strobe with the switch value, and halts RUN on a core exception.
//
// Optional feature macro: SYS_STEP_BREAKPOINT_EN (adds bp_en/bp_addr/pc_cur;
// RUN halts instead of stepping when pc_cur matches bp_addr at terminal count).
//
// Ports:
//   SYS_clk      system clock, rising edge
//   SYS_rst      synchronous active-high reset
//   key_step_n   raw step button, active-low, asynchronous
//   key_load_n   raw PC-load button, active-low, asynchronous
//   sw_run       raw run/step switch, 1 = free-run
//   sw_pc_val    PC value switches, sampled on load press
//   eh_flag      exception flag from the core
//   cpu_ce       one-cycle clock-enable to the core
//   pc_load      one-cycle PC-load strobe
//   pc_load_val  PC value latched at load
//   step_cnt     cpu_ce pulses since reset or load
//   ctrl_state   00 STEP, 01 RUN, 10 HALT
//   halted_led   high while in HALT
module sys_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned RUN_DIV    = 25000000
) (
  input  logic        SYS_clk,
  input  logic        SYS_rst,
  input  logic        key_step_n,
  input  logic        key_load_n,
  input  logic        sw_run,
  input  logic [7:0]  sw_pc_val,
  input  logic        eh_flag,
`ifdef SYS_STEP_BREAKPOINT_EN
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc_cur,
`endif
  output logic        cpu_ce,
  output logic        pc_load,
  output logic [7:0]  pc_load_val,
  output logic [15:0] step_cnt,
  output logic [1:0]  ctrl_state,
  output logic        halted_led
);

  localparam int unsigned NKEY     = 2;
  localparam int unsigned KEY_STEP = 0;
  localparam int unsigned KEY_LOAD = 1;
  localparam int unsigned DEB_W    = $clog2(DEB_CYCLES);
  localparam int unsigned DIV_W    = $clog2(RUN_DIV);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  logic [NKEY-1:0]  key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic             run_s1_q, run_s1_d, run_s2_q, run_s2_d;
  logic [NKEY-1:0]  key_acc_q, key_acc_d;
  logic [DEB_W-1:0] deb_cnt_q [NKEY];
  logic [DEB_W-1:0] deb_cnt_d [NKEY];
  logic [NKEY-1:0]  press_c;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             pc_load_q, pc_load_d;
  logic [7:0]       pc_load_val_q, pc_load_val_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             halted_q, halted_d;
  logic             do_load_c;
  logic             bp_hit_c;

`ifdef SYS_STEP_BREAKPOINT_EN
  assign bp_hit_c = bp_en && (pc_cur == bp_addr);
`else
  assign bp_hit_c = 1'b0;
`endif

  // Synchronisers and per-key debouncers; press_c marks an accepted 1->0 flip.
  always_comb begin
    key_s1_d  = {key_load_n, key_step_n};
    key_s2_d  = key_s1_q;
    run_s1_d  = sw_run;
    run_s2_d  = run_s1_q;
    key_acc_d = key_acc_q;
    press_c   = '0;
    for (int k = 0; k < NKEY; k++) begin
      deb_cnt_d[k] = '0;
      if (key_s2_q[k] != key_acc_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          key_acc_d[k] = key_s2_q[k];
          press_c[k]   = ~key_s2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
        end
      end
    end
  end

  // Control FSM: mode exits take priority over presses; load beats step.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    cpu_ce_d      = 1'b0;
    pc_load_d     = 1'b0;
    pc_load_val_d = pc_load_val_q;
    step_cnt_d    = step_cnt_q;
    do_load_c     = 1'b0;
    case (state_q)
      ST_STEP: begin
        if (run_s2_q) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (press_c[KEY_LOAD]) begin
          do_load_c = 1'b1;
        end else if (press_c[KEY_STEP]) begin
          cpu_ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (eh_flag) begin
          state_d = ST_HALT;
        end else if (!run_s2_q) begin
          state_d = ST_STEP;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bp_hit_c) state_d = ST_HALT;
          else          cpu_ce_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HALT: begin
        if (press_c[KEY_LOAD]) begin
          do_load_c = 1'b1;
        end else if (press_c[KEY_STEP]) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_STEP;
    endcase
    if (do_load_c) begin
      state_d       = ST_STEP;
      pc_load_d     = 1'b1;
      pc_load_val_d = sw_pc_val;
      step_cnt_d    = '0;
    end else if (cpu_ce_d) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      key_s1_q      <= '1;
      key_s2_q      <= '1;
      run_s1_q      <= 1'b0;
      run_s2_q      <= 1'b0;
      key_acc_q     <= '1;
      for (int k = 0; k < NKEY; k++) deb_cnt_q[k] <= '0;
      state_q       <= ST_STEP;
      div_q         <= '0;
      cpu_ce_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      step_cnt_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      run_s1_q      <= run_s1_d;
      run_s2_q      <= run_s2_d;
      key_acc_q     <= key_acc_d;
      for (int k = 0; k < NKEY; k++) deb_cnt_q[k] <= deb_cnt_d[k];
      state_q       <= state_d;
      div_q         <= div_d;
      cpu_ce_q      <= cpu_ce_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      step_cnt_q    <= step_cnt_d;
      halted_q      <= halted_d;
    end
  end

  assign cpu_ce      = cpu_ce_q;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign step_cnt    = step_cnt_q;
  assign ctrl_state  = state_q;
  assign halted_led  = halted_q;

endmodule

// File: tb/tb_sys_step_ctrl.sv
// tb_sys_step_ctrl: directed scenarios plus randomized stimulus for
// sys_step_ctrl, checked every cycle against a behavioural model.
module tb_sys_step_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_step_n, key_load_n, sw_run, eh_flag;
  logic [7:0]  sw_pc_val;
  logic        cpu_ce, pc_load, halted_led;
  logic [7:0]  pc_load_val;
  logic [15:0] step_cnt;
  logic [1:0]  ctrl_state;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sys_step_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV)) dut (
    .SYS_clk    (clk),
    .SYS_rst    (rst),
    .key_step_n (key_step_n),
    .key_load_n (key_load_n),
    .sw_run     (sw_run),
    .sw_pc_val  (sw_pc_val),
    .eh_flag    (eh_flag),
    .cpu_ce     (cpu_ce),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .step_cnt   (step_cnt),
    .ctrl_state (ctrl_state),
    .halted_led (halted_led)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 STEP, 1 RUN, 2 HALT. Debounce modelled as "level held away from
  // the accepted level for DEB consecutive synced samples".
  logic [1:0]  m_raw1, m_raw2;   // two-sample delay of raw keys {load,step}
  logic        m_run1, m_run2;
  logic [1:0]  m_acc;
  int          m_away [2];
  int          m_mode, m_run_cycles;
  logic        m_ce, m_load, m_halt;
  logic [7:0]  m_val;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    logic [1:0] pr;
    logic       run_seen;
    if (rst) begin
      m_raw1 = 2'b11; m_raw2 = 2'b11; m_run1 = 1'b0; m_run2 = 1'b0;
      m_acc = 2'b11; m_away[0] = 0; m_away[1] = 0;
      m_mode = 0; m_run_cycles = 0;
      m_ce = 1'b0; m_load = 1'b0; m_halt = 1'b0; m_val = 8'h00; m_cnt = 16'h0000;
    end else begin
      pr = 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (m_raw2[k] != m_acc[k]) begin
          m_away[k]++;
          if (m_away[k] == DEB) begin
            m_acc[k] = m_raw2[k];
            m_away[k] = 0;
            pr[k] = ~m_raw2[k];
          end
        end else m_away[k] = 0;
      end
      run_seen = m_run2;
      m_raw2 = m_raw1; m_raw1 = {key_load_n, key_step_n};
      m_run2 = m_run1; m_run1 = sw_run;
      m_ce = 1'b0; m_load = 1'b0;
      if (m_mode == 1) begin
        if (eh_flag) m_mode = 2;
        else if (!run_seen) m_mode = 0;
        else begin
          m_ce = ((m_run_cycles % DIV) == DIV - 1);
          m_run_cycles++;
        end
      end else if (m_mode == 0 && run_seen) begin
        m_mode = 1; m_run_cycles = 0;
      end else if (pr[1]) begin
        m_load = 1'b1; m_val = sw_pc_val; m_cnt = 16'h0000; m_mode = 0;
      end else if (pr[0]) begin
        if (m_mode == 0) m_ce = 1'b1;
        else m_mode = 0;
      end
      if (m_ce) m_cnt = m_cnt + 16'd1;
      m_halt = (m_mode == 2);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cpu_ce",      32'(cpu_ce),      32'(m_ce));
      chk("pc_load",     32'(pc_load),     32'(m_load));
      chk("pc_load_val", 32'(pc_load_val), 32'(m_val));
      chk("step_cnt",    32'(step_cnt),    32'(m_cnt));
      chk("ctrl_state",  32'(ctrl_state),  32'(m_mode));
      chk("halted_led",  32'(halted_led),  32'(m_halt));
      chk("ce_load_excl", 32'(cpu_ce & pc_load), 32'(0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the chosen keys low for 'hold' cycles, watches 'total' cycles.
  task automatic press_watch(input logic st, input logic ld, input int hold, input int total,
                             output int nce, output int nld, output int first);
    nce = 0; nld = 0; first = -1;
    key_step_n = ~st; key_load_n = ~ld;
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin key_step_n = 1'b1; key_load_n = 1'b1; end
      if (cpu_ce) begin nce++; if (first < 0) first = i; end
      if (pc_load) nld++;
    end
  endtask

  task automatic watch(input int total, output int nce, output int first);
    nce = 0; first = -1;
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      if (cpu_ce) begin nce++; if (first < 0) first = i; end
    end
  endtask

  initial begin
    int nce, nld, first, hs, hl;
    bit found;
    rst = 1'b1; key_step_n = 1'b1; key_load_n = 1'b1; sw_run = 1'b0;
    eh_flag = 1'b0; sw_pc_val = 8'h00;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_cpu_ce", 32'(cpu_ce), 32'(0));
    chk("rst_pc_load", 32'(pc_load), 32'(0));
    chk("rst_val", 32'(pc_load_val), 32'(0));
    chk("rst_cnt", 32'(step_cnt), 32'(0));
    chk("rst_state", 32'(ctrl_state), 32'(0));
    chk("rst_led", 32'(halted_led), 32'(0));

    // Single step: pulse 2+DEB cycles after the fall.
    press_watch(1'b1, 1'b0, 10, 18, nce, nld, first);
    chk("step_nce", 32'(nce), 32'(1));
    chk("step_latency", 32'(first), 32'(6));
    chk("step_cnt1", 32'(step_cnt), 32'(1));

    // Glitch shorter than the debounce window.
    press_watch(1'b1, 1'b0, 3, 12, nce, nld, first);
    chk("glitch_nce", 32'(nce), 32'(0));

    repeat (4) press_watch(1'b1, 1'b0, 6, 14, nce, nld, first);
    chk("step_cnt5", 32'(step_cnt), 32'(5));

    // PC load in STEP.
    sw_pc_val = 8'h3C;
    press_watch(1'b0, 1'b1, 6, 14, nce, nld, first);
    chk("load_nld", 32'(nld), 32'(1));
    chk("load_nce", 32'(nce), 32'(0));
    chk("load_val", 32'(pc_load_val), 32'(8'h3C));
    chk("load_cnt", 32'(step_cnt), 32'(0));
    chk("load_state", 32'(ctrl_state), 32'(0));

    // Free-run.
    sw_run = 1'b1;
    watch(40, nce, first);
    chk("run_nce", 32'(nce), 32'(4));
    chk("run_first", 32'(first), 32'(11));
    chk("run_state", 32'(ctrl_state), 32'(1));
    chk("run_cnt", 32'(step_cnt), 32'(4));
    sw_run = 1'b0;
    watch(20, nce, first);
    chk("stop_nce", 32'(nce), 32'(0));
    chk("stop_state", 32'(ctrl_state), 32'(0));

    // Exception on the terminal-count cycle.
    sw_run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (cpu_ce) found = 1'b1;
    end
    chk("eh_sync_found", 32'(found), 32'(1));
    tick(7);
    eh_flag = 1'b1;
    tick(1);
    eh_flag = 1'b0;
    chk("eh_no_ce", 32'(cpu_ce), 32'(0));
    chk("eh_state", 32'(ctrl_state), 32'(2));
    chk("eh_led", 32'(halted_led), 32'(1));
    sw_run = 1'b0;
    tick(4);
    chk("halt_holds", 32'(ctrl_state), 32'(2));
    press_watch(1'b1, 1'b0, 6, 14, nce, nld, first);
    chk("unhalt_nce", 32'(nce), 32'(0));
    chk("unhalt_state", 32'(ctrl_state), 32'(0));
    chk("unhalt_led", 32'(halted_led), 32'(0));

    // Simultaneous step and load: load wins.
    sw_pc_val = 8'hA5;
    press_watch(1'b1, 1'b1, 6, 14, nce, nld, first);
    chk("both_nld", 32'(nld), 32'(1));
    chk("both_nce", 32'(nce), 32'(0));
    chk("both_val", 32'(pc_load_val), 32'(8'hA5));
    press_watch(1'b1, 1'b0, 6, 14, nce, nld, first);
    chk("pre_rst_cnt", 32'(step_cnt), 32'(1));

    // Reset mid-debounce discards the press.
    key_step_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_val", 32'(pc_load_val), 32'(0));
    chk("mid_rst_cnt", 32'(step_cnt), 32'(0));
    chk("mid_rst_ce", 32'(cpu_ce), 32'(0));
    rst = 1'b0; key_step_n = 1'b1;
    watch(15, nce, first);
    chk("mid_rst_nce", 32'(nce), 32'(0));

    // Randomized phase against the model.
    hs = 1; hl = 1;
    for (int c = 0; c < 3000; c++) begin
      hs--; hl--;
      if (hs <= 0) begin key_step_n = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 12)); end
      if (hl <= 0) begin key_load_n = ($urandom_range(0, 3) != 0); hl = int'($urandom_range(1, 12)); end
      if ($urandom_range(0, 59) == 0) sw_run = ~sw_run;
      eh_flag   = ($urandom_range(0, 39) == 0);
      sw_pc_val = 8'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; eh_flag = 1'b0;
    tick(2);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
